// File: rtl/ejtag_dma_pkg.sv
// Shared types and lane helpers for the EJTAG DMA bus master.
package ejtag_dma_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } dma_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } dma_state_t;

    // Reserved size and any access not aligned to its own size are refused.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            SZ_WORD: return (lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] rep_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    // Selected lane is moved down to bit 0 and zero-extended.
    function automatic logic [31:0] read_lane(input logic [1:0] size, input logic [1:0] lo,
                                              input logic [31:0] rdata);
        logic [31:0] shifted;
        shifted = rdata >> {lo, 3'b000};
        case (size)
            SZ_BYTE: return {24'h0, shifted[7:0]};
            SZ_HALF: return {16'h0, shifted[15:0]};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/ejtag_dma_master_if.sv
// Local-bus request/response signals between the DMA master and the bus.
interface ejtag_dma_master_if;
    logic        EJDM_BUSREQ;
    logic [31:0] EJDM_BUSADDR;
    logic [31:0] EJDM_BUSWDATA;
    logic [3:0]  EJDM_BUSBE;
    logic        EJDM_BUSRNW;
    logic        BUS_ACK;
    logic [31:0] BUS_RDATA;
    logic        BUS_ERR;

    modport master (
        output EJDM_BUSREQ, EJDM_BUSADDR, EJDM_BUSWDATA, EJDM_BUSBE, EJDM_BUSRNW,
        input  BUS_ACK, BUS_RDATA, BUS_ERR
    );

    modport slave (
        input  EJDM_BUSREQ, EJDM_BUSADDR, EJDM_BUSWDATA, EJDM_BUSBE, EJDM_BUSRNW,
        output BUS_ACK, BUS_RDATA, BUS_ERR
    );
endinterface

// File: rtl/ejtag_tgl_sync.sv
// Brings the JTAG-side request toggle into the core clock and flags an unserviced edge.
module ejtag_tgl_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CORE_CLOCK,
    input  logic RESET_D1_R,
    input  logic tgl_async,
    input  logic accept,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_seen_q;

    // Accepting copies the synchronised level, so one toggle edge yields one access.
    always_ff @(posedge CORE_CLOCK) begin
        if (RESET_D1_R) begin
            sync_q      <= '0;
            last_seen_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_async};
            if (accept) begin
                last_seen_q <= sync_q[SYNC_STAGES-1];
            end
        end
    end

    assign pending = sync_q[SYNC_STAGES-1] ^ last_seen_q;

endmodule

// File: rtl/ejtag_dma_master.sv
// Core-clock DMA master: turns one JTAG request toggle into one local-bus access
// and returns completion as a toggle with status and right-justified read data.
module ejtag_dma_master
    import ejtag_dma_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 8
) (
    input  logic        CORE_CLOCK,
    input  logic        RESET_D1_R,
    input  logic [31:0] EJDD_DATA,
    input  logic [31:0] EJDD_ADDR,
    input  logic        EJC_DMAREQ_TGL,
    input  logic        EJC_DMARNW,
    input  logic [1:0]  EJC_DMASIZE,
    output logic        EJDM_ACK_TGL,
    output logic        EJDM_ERR,
    output logic [31:0] LBC_EJDATA,
    output logic        LBC_EVAL,
    ejtag_dma_master_if.master bus
);

    localparam logic [TIMEOUT_W-1:0] TMO_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    dma_state_t           state;
    logic                 req_pending;
    logic                 accept;
    logic                 rnw_q;
    logic [1:0]           size_q;
    logic [1:0]           lo_q;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 busreq_q;
    logic [31:0]          busaddr_q;
    logic [31:0]          buswdata_q;
    logic [3:0]           busbe_q;
    logic                 busrnw_q;

    assign accept = (state == IDLE) && req_pending;

    ejtag_tgl_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tgl_sync (
        .CORE_CLOCK (CORE_CLOCK),
        .RESET_D1_R (RESET_D1_R),
        .tgl_async  (EJC_DMAREQ_TGL),
        .accept     (accept),
        .pending    (req_pending)
    );

    // Ending one cycle before the counter saturates gives exactly 2**TIMEOUT_W-1 request cycles.
    always_ff @(posedge CORE_CLOCK) begin
        if (RESET_D1_R) begin
            state        <= IDLE;
            rnw_q        <= 1'b0;
            size_q       <= 2'b00;
            lo_q         <= 2'b00;
            tmo_cnt      <= '0;
            busreq_q     <= 1'b0;
            busaddr_q    <= '0;
            buswdata_q   <= '0;
            busbe_q      <= '0;
            busrnw_q     <= 1'b0;
            EJDM_ACK_TGL <= 1'b0;
            EJDM_ERR     <= 1'b0;
            LBC_EJDATA   <= '0;
            LBC_EVAL     <= 1'b0;
        end else begin
            LBC_EVAL <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_pending) begin
                        rnw_q      <= EJC_DMARNW;
                        size_q     <= EJC_DMASIZE;
                        lo_q       <= EJDD_ADDR[1:0];
                        tmo_cnt    <= '0;
                        busaddr_q  <= {EJDD_ADDR[31:2], 2'b00};
                        buswdata_q <= rep_wdata(EJC_DMASIZE, EJDD_DATA);
                        busbe_q    <= gen_be(EJC_DMASIZE, EJDD_ADDR[1:0]);
                        busrnw_q   <= EJC_DMARNW;
                        if (is_illegal(EJC_DMASIZE, EJDD_ADDR[1:0])) begin
                            state        <= DONE;
                            EJDM_ERR     <= 1'b1;
                            EJDM_ACK_TGL <= ~EJDM_ACK_TGL;
                        end else begin
                            state    <= ISSUE;
                            EJDM_ERR <= 1'b0;
                            busreq_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                    if (bus.BUS_ACK) begin
                        state        <= DONE;
                        busreq_q     <= 1'b0;
                        EJDM_ACK_TGL <= ~EJDM_ACK_TGL;
                        EJDM_ERR     <= bus.BUS_ERR;
                        if (rnw_q && !bus.BUS_ERR) begin
                            LBC_EVAL   <= 1'b1;
                            LBC_EJDATA <= read_lane(size_q, lo_q, bus.BUS_RDATA);
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state        <= DONE;
                        busreq_q     <= 1'b0;
                        EJDM_ACK_TGL <= ~EJDM_ACK_TGL;
                        EJDM_ERR     <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    busreq_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.EJDM_BUSREQ   = busreq_q;
    assign bus.EJDM_BUSADDR  = busaddr_q;
    assign bus.EJDM_BUSWDATA = buswdata_q;
    assign bus.EJDM_BUSBE    = busbe_q;
    assign bus.EJDM_BUSRNW   = busrnw_q;

endmodule

// File: tb/tb_ejtag_dma_master.sv
// Scoreboard bench for ejtag_dma_master: stimulus queues expected bus/completion
// records, a responder plays the bus slave, and a monitor pops and compares.
module tb_ejtag_dma_master;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rnw;
        int          len;
        int          gap;
    } bus_exp_t;

    typedef struct {
        logic        err;
        logic        eval;
        logic [31:0] ejdata;
    } done_exp_t;

    typedef struct {
        int          delay;
        logic        noack;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        CORE_CLOCK;
    logic        RESET_D1_R;
    logic [31:0] EJDD_DATA;
    logic [31:0] EJDD_ADDR;
    logic        EJC_DMAREQ_TGL;
    logic        EJC_DMARNW;
    logic [1:0]  EJC_DMASIZE;
    logic        EJDM_ACK_TGL;
    logic        EJDM_ERR;
    logic [31:0] LBC_EJDATA;
    logic        LBC_EVAL;

    ejtag_dma_master_if bus ();

    ejtag_dma_master #(
        .SYNC_STAGES (2),
        .TIMEOUT_W   (4)
    ) dut (
        .CORE_CLOCK     (CORE_CLOCK),
        .RESET_D1_R     (RESET_D1_R),
        .EJDD_DATA      (EJDD_DATA),
        .EJDD_ADDR      (EJDD_ADDR),
        .EJC_DMAREQ_TGL (EJC_DMAREQ_TGL),
        .EJC_DMARNW     (EJC_DMARNW),
        .EJC_DMASIZE    (EJC_DMASIZE),
        .EJDM_ACK_TGL   (EJDM_ACK_TGL),
        .EJDM_ERR       (EJDM_ERR),
        .LBC_EJDATA     (LBC_EJDATA),
        .LBC_EVAL       (LBC_EVAL),
        .bus            (bus)
    );

    initial CORE_CLOCK = 1'b0;
    always #5 CORE_CLOCK = ~CORE_CLOCK;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];
    rsp_t      rsp_q[$];
    int        checks = 0;
    int        errors = 0;
    logic      req_tgl = 1'b0;

    localparam rsp_t      NO_RSP  = '{0, 1'b1, 32'h0, 1'b0};
    localparam bus_exp_t  NO_BUS  = '{32'h0, 4'h0, 32'h0, 1'b0, 0, 0};
    localparam done_exp_t NO_DONE = '{1'b0, 1'b0, 32'h0};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rnw, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic has_bus, input bus_exp_t bx, input rsp_t rx,
                                 input logic has_done, input done_exp_t dx);
        @(negedge CORE_CLOCK);
        EJDD_ADDR   = addr;
        EJDD_DATA   = data;
        EJC_DMARNW  = rnw;
        EJC_DMASIZE = size;
        if (has_bus) begin
            bus_q.push_back(bx);
            rsp_q.push_back(rx);
        end
        if (has_done) done_q.push_back(dx);
        req_tgl        = ~req_tgl;
        EJC_DMAREQ_TGL = req_tgl;
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while ((done_q.size() != 0 || bus_q.size() != 0) && n < 100) begin
            @(negedge CORE_CLOCK);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_wait: bus=%0d done=%0d records outstanding, expected 0",
                     name, bus_q.size(), done_q.size());
            bus_q.delete();
            done_q.delete();
        end
        repeat (3) @(negedge CORE_CLOCK);
    endtask

    task automatic waitBusReq(input string name);
        int n = 0;
        while (!bus.EJDM_BUSREQ && n < 50) begin
            @(posedge CORE_CLOCK);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_busreq: got BUSREQ=0 for 50 cycles, expected 1", name);
        end
    endtask

    // Bus slave: acks `delay` cycles after BUSREQ first appears, or never.
    initial begin : responder
        rsp_t rc;
        int   rsp_cnt;
        logic rsp_active;
        logic rsp_done;
        rc          = NO_RSP;
        rsp_cnt     = 0;
        rsp_active  = 1'b0;
        rsp_done    = 1'b0;
        bus.BUS_ACK   = 1'b0;
        bus.BUS_ERR   = 1'b0;
        bus.BUS_RDATA = 32'h0;
        forever begin
            @(posedge CORE_CLOCK);
            #1;
            bus.BUS_ACK   = 1'b0;
            bus.BUS_ERR   = 1'b0;
            bus.BUS_RDATA = 32'hDEAD_0000;
            if (RESET_D1_R || !bus.EJDM_BUSREQ) begin
                rsp_active = 1'b0;
                rsp_done   = 1'b0;
            end else if (!rsp_done) begin
                if (!rsp_active) begin
                    rsp_active = 1'b1;
                    rsp_cnt    = 0;
                    rc         = (rsp_q.size() != 0) ? rsp_q.pop_front() : NO_RSP;
                end
                if (!rc.noack && rsp_cnt == rc.delay) begin
                    bus.BUS_ACK   = 1'b1;
                    bus.BUS_ERR   = rc.err;
                    bus.BUS_RDATA = rc.rdata;
                    rsp_done      = 1'b1;
                end
                rsp_cnt++;
            end
        end
    end

    // Monitor: pops a bus record on each BUSREQ rise and a completion record on each ACK_TGL edge.
    initial begin : monitor
        bus_exp_t  cur;
        done_exp_t d;
        logic      prev_req;
        logic      prev_ack;
        logic      post_done;
        int        cyc;
        int        fall_cyc;
        int        req_len;
        cur       = NO_BUS;
        d         = NO_DONE;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        post_done = 1'b0;
        cyc       = 0;
        fall_cyc  = 0;
        req_len   = 0;
        forever begin
            @(posedge CORE_CLOCK);
            #1;
            cyc++;
            if (RESET_D1_R) begin
                post_done = 1'b0;
                req_len   = 0;
            end else begin
                if (post_done) begin
                    checkOutput("eval_one_cycle", 32'(LBC_EVAL), 32'h0);
                    post_done = 1'b0;
                end else if (LBC_EVAL && EJDM_ACK_TGL == prev_ack) begin
                    checkOutput("eval_spurious", 32'(LBC_EVAL), 32'h0);
                end
                if (bus.EJDM_BUSREQ && !prev_req) begin
                    if (bus_q.size() == 0) begin
                        checkOutput("busreq_unexpected", 32'(bus.EJDM_BUSREQ), 32'h0);
                        cur = NO_BUS;
                    end else begin
                        cur = bus_q.pop_front();
                        checkOutput("busaddr", bus.EJDM_BUSADDR, cur.addr);
                        checkOutput("busbe", 32'(bus.EJDM_BUSBE), 32'(cur.be));
                        checkOutput("buswdata", bus.EJDM_BUSWDATA, cur.wdata);
                        checkOutput("busrnw", 32'(bus.EJDM_BUSRNW), 32'(cur.rnw));
                        checkOutput("err_cleared_at_accept", 32'(EJDM_ERR), 32'h0);
                        if (cur.gap != 0) checkOutput("busreq_gap", 32'(cyc - fall_cyc), 32'(cur.gap));
                    end
                    req_len = 0;
                end
                if (bus.EJDM_BUSREQ) req_len++;
                if (!bus.EJDM_BUSREQ && prev_req) begin
                    fall_cyc = cyc;
                    if (cur.len != 0) checkOutput("busreq_len", 32'(req_len), 32'(cur.len));
                end
                if (EJDM_ACK_TGL != prev_ack) begin
                    if (done_q.size() == 0) begin
                        checkOutput("ack_unexpected", 32'(EJDM_ACK_TGL), 32'(prev_ack));
                    end else begin
                        d = done_q.pop_front();
                        checkOutput("done_err", 32'(EJDM_ERR), 32'(d.err));
                        checkOutput("done_eval", 32'(LBC_EVAL), 32'(d.eval));
                        checkOutput("done_ejdata", LBC_EJDATA, d.ejdata);
                        checkOutput("done_busreq", 32'(bus.EJDM_BUSREQ), 32'h0);
                    end
                    post_done = 1'b1;
                end
            end
            prev_req = bus.EJDM_BUSREQ;
            prev_ack = EJDM_ACK_TGL;
        end
    end

    initial begin : stimulus
        RESET_D1_R     = 1'b1;
        EJDD_DATA      = 32'h0;
        EJDD_ADDR      = 32'h0;
        EJC_DMAREQ_TGL = 1'b0;
        EJC_DMARNW     = 1'b0;
        EJC_DMASIZE    = 2'd0;
        repeat (3) @(posedge CORE_CLOCK);
        #1;
        checkOutput("rst_busreq", 32'(bus.EJDM_BUSREQ), 32'h0);
        checkOutput("rst_ack_tgl", 32'(EJDM_ACK_TGL), 32'h0);
        checkOutput("rst_err", 32'(EJDM_ERR), 32'h0);
        checkOutput("rst_eval", 32'(LBC_EVAL), 32'h0);
        checkOutput("rst_ejdata", LBC_EJDATA, 32'h0);
        checkOutput("rst_busaddr", bus.EJDM_BUSADDR, 32'h0);
        checkOutput("rst_busbe", 32'(bus.EJDM_BUSBE), 32'h0);
        @(negedge CORE_CLOCK);
        RESET_D1_R = 1'b0;
        repeat (2) @(negedge CORE_CLOCK);

        $display("[TB] word write");
        applyStimulus(1'b0, 2'd2, 32'h1000_0008, 32'hCAFE_F00D,
                      1'b1, '{32'h1000_0008, 4'b1111, 32'hCAFE_F00D, 1'b0, 4, 0}, '{3, 1'b0, 32'h0, 1'b0},
                      1'b1, '{1'b0, 1'b0, 32'h0});
        waitDone("word_write");

        $display("[TB] byte read lane 3");
        applyStimulus(1'b1, 2'd0, 32'h2000_0003, 32'h0000_00AB,
                      1'b1, '{32'h2000_0000, 4'b1000, 32'hABAB_ABAB, 1'b1, 2, 0}, '{1, 1'b0, 32'h1122_3344, 1'b0},
                      1'b1, '{1'b0, 1'b1, 32'h0000_0011});
        waitDone("byte_read");

        $display("[TB] half write upper");
        applyStimulus(1'b0, 2'd1, 32'h3000_0002, 32'h0000_BEEF,
                      1'b1, '{32'h3000_0000, 4'b1100, 32'hBEEF_BEEF, 1'b0, 1, 0}, '{0, 1'b0, 32'h0, 1'b0},
                      1'b1, '{1'b0, 1'b0, 32'h0000_0011});
        waitDone("half_write");

        $display("[TB] misaligned half read");
        applyStimulus(1'b1, 2'd1, 32'h3000_0001, 32'h0,
                      1'b0, NO_BUS, NO_RSP, 1'b1, '{1'b1, 1'b0, 32'h0000_0011});
        waitDone("half_misaligned");

        $display("[TB] timeout");
        applyStimulus(1'b1, 2'd2, 32'h4000_0000, 32'h1234_5678,
                      1'b1, '{32'h4000_0000, 4'b1111, 32'h1234_5678, 1'b1, 15, 0}, NO_RSP,
                      1'b1, '{1'b1, 1'b0, 32'h0000_0011});
        waitDone("timeout");

        $display("[TB] ack on last timeout cycle");
        applyStimulus(1'b1, 2'd2, 32'h4000_0010, 32'h0,
                      1'b1, '{32'h4000_0010, 4'b1111, 32'h0, 1'b1, 15, 0}, '{14, 1'b0, 32'h1357_9BDF, 1'b0},
                      1'b1, '{1'b0, 1'b1, 32'h1357_9BDF});
        waitDone("ack_vs_timeout");

        $display("[TB] half read upper");
        applyStimulus(1'b1, 2'd1, 32'h4000_0002, 32'h0,
                      1'b1, '{32'h4000_0000, 4'b1100, 32'h0, 1'b1, 3, 0}, '{2, 1'b0, 32'hA5A5_5A5A, 1'b0},
                      1'b1, '{1'b0, 1'b1, 32'h0000_A5A5});
        waitDone("half_read");

        $display("[TB] byte read with bus error");
        applyStimulus(1'b1, 2'd0, 32'h5000_0001, 32'h0,
                      1'b1, '{32'h5000_0000, 4'b0010, 32'h0, 1'b1, 1, 0}, '{0, 1'b0, 32'hFFFF_FFFF, 1'b1},
                      1'b1, '{1'b1, 1'b0, 32'h0000_A5A5});
        waitDone("bus_error");

        $display("[TB] byte write lane 2");
        applyStimulus(1'b0, 2'd0, 32'h6000_0002, 32'h0000_00C3,
                      1'b1, '{32'h6000_0000, 4'b0100, 32'hC3C3_C3C3, 1'b0, 2, 0}, '{1, 1'b0, 32'h0, 1'b0},
                      1'b1, '{1'b0, 1'b0, 32'h0000_A5A5});
        waitDone("byte_write");

        $display("[TB] misaligned word and reserved size");
        applyStimulus(1'b0, 2'd2, 32'h6000_0001, 32'h0,
                      1'b0, NO_BUS, NO_RSP, 1'b1, '{1'b1, 1'b0, 32'h0000_A5A5});
        waitDone("word_misaligned");
        applyStimulus(1'b1, 2'd3, 32'h6000_0000, 32'h0,
                      1'b0, NO_BUS, NO_RSP, 1'b1, '{1'b1, 1'b0, 32'h0000_A5A5});
        waitDone("size_reserved");

        $display("[TB] second edge while busy");
        applyStimulus(1'b0, 2'd2, 32'h8000_0000, 32'h0102_0304,
                      1'b1, '{32'h8000_0000, 4'b1111, 32'h0102_0304, 1'b0, 5, 0}, '{4, 1'b0, 32'h0, 1'b0},
                      1'b1, '{1'b0, 1'b0, 32'h0000_A5A5});
        waitBusReq("b2b_first");
        applyStimulus(1'b1, 2'd2, 32'h8000_0004, 32'h0,
                      1'b1, '{32'h8000_0004, 4'b1111, 32'h0, 1'b1, 1, 2}, '{0, 1'b0, 32'h0BAD_F00D, 1'b0},
                      1'b1, '{1'b0, 1'b1, 32'h0BAD_F00D});
        waitDone("back_to_back");

        $display("[TB] reset during bus cycle");
        applyStimulus(1'b1, 2'd2, 32'h9000_0000, 32'h0,
                      1'b1, '{32'h9000_0000, 4'b1111, 32'h0, 1'b1, 0, 0}, '{30, 1'b0, 32'h0, 1'b0},
                      1'b0, NO_DONE);
        waitBusReq("reset_mid");
        repeat (2) @(negedge CORE_CLOCK);
        RESET_D1_R     = 1'b1;
        req_tgl        = 1'b0;
        EJC_DMAREQ_TGL = 1'b0;
        @(posedge CORE_CLOCK);
        #1;
        checkOutput("midrst_busreq", 32'(bus.EJDM_BUSREQ), 32'h0);
        checkOutput("midrst_ack_tgl", 32'(EJDM_ACK_TGL), 32'h0);
        checkOutput("midrst_eval", 32'(LBC_EVAL), 32'h0);
        checkOutput("midrst_err", 32'(EJDM_ERR), 32'h0);
        checkOutput("midrst_ejdata", LBC_EJDATA, 32'h0);
        checkOutput("midrst_busaddr", bus.EJDM_BUSADDR, 32'h0);
        @(negedge CORE_CLOCK);
        RESET_D1_R = 1'b0;
        repeat (3) @(negedge CORE_CLOCK);

        $display("[TB] read after reset");
        applyStimulus(1'b1, 2'd2, 32'h7000_0004, 32'h0,
                      1'b1, '{32'h7000_0004, 4'b1111, 32'h0, 1'b1, 2, 0}, '{1, 1'b0, 32'hDEAD_BEEF, 1'b0},
                      1'b1, '{1'b0, 1'b1, 32'hDEAD_BEEF});
        waitDone("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
